// File: rtl/phase_gen_pkg.sv
// Shared constants for the phase generator and downstream sin/cos stage.
// Phase format is signed 1.2.5 radians, LSB = 1/32 rad.
package phase_gen_pkg;

    localparam int PW_DEF   = 8;
    localparam int RW_DEF   = 8;
    localparam int PI_Q     = 100;
    localparam int TWO_PI_Q = 201;

endpackage

// File: rtl/phase_gen_if.sv
// Control and sample bus between phase_gen and its driver / consumer.
// The master drives controls and receives samples.
interface phase_gen_if
    import phase_gen_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int RW = RW_DEF
);

    logic                 i_en;
    logic                 i_load;
    logic signed [PW-1:0] i_init_phase;
    logic signed [PW-1:0] i_step;
    logic [RW-1:0]        i_rate;
    logic signed [PW-1:0] o_phase;
    logic                 o_valid;
    logic                 o_wrap;

    modport master (
        output i_en, i_load, i_init_phase, i_step, i_rate,
        input  o_phase, o_valid, o_wrap
    );

    modport slave (
        input  i_en, i_load, i_init_phase, i_step, i_rate,
        output o_phase, o_valid, o_wrap
    );

endinterface

// File: rtl/phase_wrap.sv
// Combinational phase limiter: saturates (WRAP=0) or wraps by 2*pi
// (WRAP=1) a PW+1 bit value into [-PI_Q, +PI_Q].
module phase_wrap
    import phase_gen_pkg::*;
#(
    parameter int PW   = PW_DEF,
    parameter bit WRAP = 1'b0
) (
    input  logic signed [PW:0]   i_val,
    output logic signed [PW-1:0] o_val,
    output logic                 o_hit
);

    localparam logic signed [PW:0] PI_V  = (PW+1)'(PI_Q);
    localparam logic signed [PW:0] TPI_V = (PW+1)'(TWO_PI_Q);

    logic signed [PW:0] res;

    always_comb begin
        res   = i_val;
        o_hit = 1'b0;
        if (i_val > PI_V) begin
            res   = WRAP ? (i_val - TPI_V) : PI_V;
            o_hit = 1'b1;
        end else if (i_val < -PI_V) begin
            res   = WRAP ? (i_val + TPI_V) : -PI_V;
            o_hit = 1'b1;
        end
        o_val = res[PW-1:0];
    end

endmodule

// File: rtl/phase_gen.sv
// Phase accumulator emitting one wrapped phase sample every i_rate+1
// enabled cycles, feeding the sin/cos CORDIC stage.
module phase_gen
    import phase_gen_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int RW = RW_DEF
) (
    input logic        i_clk,
    input logic        i_rst,
    phase_gen_if.slave bus
);

    logic signed [PW-1:0] step_c;
    logic signed [PW-1:0] init_c;
    logic signed [PW-1:0] acc_nxt;
    logic signed [PW:0]   sum;
    logic                 acc_hit;
    logic                 step_hit;
    logic                 init_hit;
    logic                 unused_hits;
    logic                 tick;

    logic signed [PW-1:0] acc_q, acc_d;
    logic [RW-1:0]        cnt_q, cnt_d;
    logic signed [PW-1:0] phase_q, phase_d;
    logic                 valid_q, valid_d;
    logic                 wrap_q, wrap_d;
    logic                 pend_q, pend_d;

    phase_wrap #(.PW(PW), .WRAP(1'b0)) u_step_sat (
        .i_val ({bus.i_step[PW-1], bus.i_step}),
        .o_val (step_c),
        .o_hit (step_hit)
    );

    phase_wrap #(.PW(PW), .WRAP(1'b0)) u_init_sat (
        .i_val ({bus.i_init_phase[PW-1], bus.i_init_phase}),
        .o_val (init_c),
        .o_hit (init_hit)
    );

    assign sum = {acc_q[PW-1], acc_q} + {step_c[PW-1], step_c};

    phase_wrap #(.PW(PW), .WRAP(1'b1)) u_acc_wrap (
        .i_val (sum),
        .o_val (acc_nxt),
        .o_hit (acc_hit)
    );

    assign unused_hits = step_hit ^ init_hit;
    assign tick        = bus.i_en && (cnt_q >= bus.i_rate);

    // pend_q marks that acc holds a freshly wrapped value, so the flag
    // rides out with the sample that carries the wrapped phase.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        pend_d  = pend_q;
        if (bus.i_load) begin
            acc_d  = init_c;
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (tick) begin
            phase_d = acc_q;
            valid_d = 1'b1;
            wrap_d  = pend_q;
            acc_d   = acc_nxt;
            pend_d  = acc_hit;
            cnt_d   = '0;
        end else if (bus.i_en) begin
            cnt_d = cnt_q + RW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            phase_q <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.o_phase = phase_q;
    assign bus.o_valid = valid_q;
    assign bus.o_wrap  = wrap_q;

endmodule

// File: tb/tb_phase_gen.sv
// Self-checking bench for phase_gen: vector table, corner sequences
// and a randomized run against an integer reference model.
module tb_phase_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    phase_gen_if #(.PW(8), .RW(8)) bus ();

    phase_gen #(.PW(8), .RW(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit load;
        bit en;
        int init;
        int step;
        int rate;
        bit ev;
        int ep;
        bit ew;
    } vec_t;

    vec_t tv[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int m_acc, m_cnt, m_phase;
    bit m_valid, m_wrap, m_pend;

    function automatic int clampf(int v);
        if (v > 100) return 100;
        if (v < -100) return -100;
        return v;
    endfunction

    function automatic int wrapf(int v);
        int m;
        m = (v + 100) % 201;
        if (m < 0) m += 201;
        return m - 100;
    endfunction

    task automatic model_step();
        int s;
        if (rst) begin
            m_acc = 0; m_cnt = 0; m_phase = 0;
            m_valid = 0; m_wrap = 0; m_pend = 0;
        end else if (bus.i_load) begin
            m_acc = clampf(int'(bus.i_init_phase));
            m_cnt = 0; m_valid = 0; m_wrap = 0; m_pend = 0;
        end else if (bus.i_en && m_cnt >= int'(bus.i_rate)) begin
            s = m_acc + clampf(int'(bus.i_step));
            m_phase = m_acc;
            m_valid = 1;
            m_wrap  = m_pend;
            m_acc   = wrapf(s);
            m_pend  = (m_acc != s);
            m_cnt   = 0;
        end else begin
            m_valid = 0; m_wrap = 0;
            if (bus.i_en) m_cnt++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ph();
        return int'(bus.o_phase);
    endfunction

    task automatic drive(bit ld, bit en, int init, int step, int rate);
        bus.i_load       = ld;
        bus.i_en         = en;
        bus.i_init_phase = 8'(init);
        bus.i_step       = 8'(step);
        bus.i_rate       = 8'(rate);
    endtask

    task automatic chk_model(string nm);
        chk({nm, "_phase"}, ph(), m_phase);
        chk({nm, "_valid"}, int'(bus.o_valid), int'(m_valid));
        chk({nm, "_wrap"},  int'(bus.o_wrap),  int'(m_wrap));
    endtask

    initial begin
        int n, np;
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("rst_phase", ph(), 0);
            chk("rst_valid", int'(bus.o_valid), 0);
            chk("rst_wrap",  int'(bus.o_wrap), 0);
        end
        rst = 1'b0;

        tv.push_back('{1, 0,    0,  32, 0, 0,    0, 0});
        tv.push_back('{0, 1,    0,  32, 0, 1,    0, 0});
        tv.push_back('{0, 1,    0,  32, 0, 1,   32, 0});
        tv.push_back('{0, 1,    0,  32, 0, 1,   64, 0});
        tv.push_back('{0, 1,    0,  32, 0, 1,   96, 0});
        tv.push_back('{0, 1,    0,  32, 0, 1,  -73, 1});
        tv.push_back('{0, 1,    0,  32, 0, 1,  -41, 0});
        tv.push_back('{1, 1,  -80, -50, 0, 0,  -41, 0});
        tv.push_back('{0, 1,  -80, -50, 0, 1,  -80, 0});
        tv.push_back('{0, 1,  -80, -50, 0, 1,   71, 1});
        tv.push_back('{0, 1,  -80, -50, 0, 1,   21, 0});
        tv.push_back('{0, 1,  -80, -50, 0, 1,  -29, 0});
        tv.push_back('{1, 1,   50,  10, 0, 0,  -29, 0});
        tv.push_back('{0, 1,   50,  10, 0, 1,   50, 0});
        tv.push_back('{1, 1, -128, 120, 0, 0,   50, 0});
        tv.push_back('{0, 1, -128, 120, 0, 1, -100, 0});
        tv.push_back('{0, 1, -128, 120, 0, 1,    0, 0});
        tv.push_back('{0, 1, -128, 120, 0, 1,  100, 0});
        tv.push_back('{0, 1, -128, 120, 0, 1,   -1, 1});

        foreach (tv[k]) begin
            drive(tv[k].load, tv[k].en, tv[k].init,
                  tv[k].step, tv[k].rate);
            cyc();
            chk($sformatf("vec%0d_valid", k), int'(bus.o_valid),
                int'(tv[k].ev));
            chk($sformatf("vec%0d_phase", k), ph(), tv[k].ep);
            chk($sformatf("vec%0d_wrap", k), int'(bus.o_wrap),
                int'(tv[k].ew));
        end

        drive(1, 0, 0, 10, 3);
        cyc();
        bus.i_load = 0;
        bus.i_en   = 1;
        np = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            chk("r3_pattern", int'(bus.o_valid), (i % 4 == 3) ? 1 : 0);
            if (bus.o_valid) np++;
        end
        chk("r3_count", np, 10);
        chk("r3_last", ph(), 90);
        bus.i_en = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("en_low_valid", int'(bus.o_valid), 0);
            chk("en_low_phase", ph(), 90);
        end
        bus.i_en = 1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.o_valid && n < 20);
        chk("resume_gap", n, 4);
        chk("resume_phase", ph(), 100);

        drive(1, 1, 0, 10, 10);
        cyc();
        bus.i_load = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("r10_idle", int'(bus.o_valid), 0);
        end
        bus.i_rate = 8'd2;
        cyc();
        chk("rate_drop_valid", int'(bus.o_valid), 1);
        chk("rate_drop_phase", ph(), 0);

        drive(1, 1, 0, 20, 2);
        cyc();
        bus.i_load = 0;
        for (int i = 0; i < 7; i++) cyc();
        chk("pre_rst_phase", ph(), 20);
        rst = 1'b1;
        cyc();
        chk("midrst_phase", ph(), 0);
        chk("midrst_valid", int'(bus.o_valid), 0);
        chk("midrst_wrap",  int'(bus.o_wrap), 0);
        rst = 1'b0;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.o_valid && n < 20);
        chk("post_rst_gap", n, 3);
        chk("post_rst_phase", ph(), 0);

        drive(1, 1, -128, 120, 0);
        cyc();
        bus.i_load = 0;
        for (int i = 0; i < 500; i++) begin
            cyc();
            chk("sat_valid", int'(bus.o_valid), 1);
            chk("sat_range", (ph() >= -100 && ph() <= 100) ? 1 : 0, 1);
        end

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(199) == 0);
            bus.i_en   = ($urandom_range(99) < 85);
            bus.i_load = ($urandom_range(39) == 0);
            bus.i_init_phase = 8'($urandom);
            bus.i_step       = 8'($urandom);
            if ($urandom_range(15) == 0)
                bus.i_rate = 8'($urandom_range(5));
            cyc();
            chk_model("rand");
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/phase_gen.md
PHASE_GEN -- requirements
Module: phase_gen

Interface
REQ-001 Parameter PW, default 8, phase width; phase format is signed fixed-point 1.2.5 (radians, LSB = 1/32 rad).
REQ-002 Parameter RW, default 8, width of the sample-interval input.
REQ-003 i_clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 i_rst, input, 1, reset; synchronous, active-high.
REQ-005 i_en, input, 1, run enable; low freezes the interval counter and the accumulator.
REQ-006 i_load, input, 1, one-cycle strobe that loads i_init_phase and restarts the interval count.
REQ-007 i_init_phase, input, PW, signed initial phase, sampled only when i_load=1.
REQ-008 i_step, input, PW, signed phase increment per output sample, sampled continuously.
REQ-009 i_rate, input, RW, unsigned idle cycles between samples; 0 means one sample every cycle.
REQ-010 o_phase, output, PW, registered phase sample for the downstream sin/cos CORDIC stage.
REQ-011 o_valid, output, 1, registered one-cycle strobe qualifying o_phase.
REQ-012 o_wrap, output, 1, registered strobe, high with o_valid when the accumulator wrapped on that advance.

Function
REQ-013 Constants: PI_Q = 100 (3.125 rad); TWO_PI_Q = 201; the legal phase range is [-PI_Q, +PI_Q].
REQ-014 i_step and i_init_phase SHALL be saturated to [-PI_Q, +PI_Q] before use.
REQ-015 The interval counter SHALL count 0 upward while i_en=1; a tick occurs when the counter >= i_rate, and the counter then returns to 0.
REQ-016 On a tick: o_phase <= acc, o_valid <= 1, and acc <= wrap(acc + step), all in the same cycle; latency from tick to o_valid is 1 cycle.
REQ-017 wrap(): form the sum at PW+1 bits; if sum > PI_Q, subtract TWO_PI_Q; if sum < -PI_Q, add TWO_PI_Q; otherwise pass the sum through. The result SHALL always lie in [-PI_Q, +PI_Q].
REQ-018 o_wrap SHALL be 1 on the o_valid cycle whose accumulator update wrapped, and 0 otherwise.
REQ-019 Off-tick cycles: o_valid=0, o_wrap=0, and o_phase holds its last value.
REQ-020 i_load=1 SHALL have priority over a tick in the same cycle: acc <= clamp(i_init_phase), counter <= 0, o_valid <= 0; this load takes effect regardless of i_en.
REQ-021 The first sample after a load SHALL equal the clamped initial phase.
REQ-022 When i_en=0, o_valid=0 and the counter and acc hold their values; when i_en returns to 1, operation resumes from the held count.
REQ-023 A change of i_rate mid-count SHALL take effect immediately through the >= compare, so a reduction never stalls the counter.

Reset
REQ-024 While i_rst=1: acc=0, counter=0, o_phase=0, o_valid=0, o_wrap=0; i_rst has priority over i_load and i_en.
REQ-025 Reset asserted mid-interval SHALL discard the partial count; the first tick after release comes i_rate+1 enabled cycles later.

Structure
REQ-026 A shared package SHALL hold PI_Q, TWO_PI_Q, and the default PW/RW for reuse by the sincos stage and its testbenches.
REQ-027 The saturate and wrap arithmetic SHALL live in one combinational sub-module, phase_wrap, instantiated for the step/init clamp and for the accumulator update.

Verification
REQ-028 rst, load init=0, step=32, rate=0, en=1 -> o_valid every cycle with o_phase 0, 32, 64, 96, -73 (o_wrap=1 on that sample), -41.
REQ-029 load init=-80, step=-50, rate=0 -> o_phase -80, 71 (o_wrap=1), 21, -29.
REQ-030 rate=3, step=10 -> o_valid exactly once per 4 enabled cycles; i_en low for 5 cycles inserts no pulses and no phase advance.
REQ-031 step=120, init=-128 -> treated as step=100, init=-100; every o_phase stays within [-100, 100] over 500 samples.
REQ-032 i_load with a tick due in the same cycle -> no o_valid that cycle; the next sample equals the loaded phase.
REQ-033 i_rst pulsed mid-run with rate=2 -> all outputs 0 the cycle after reset; the first o_valid comes 3 enabled cycles after release, with o_phase=0.
